// File: rtl/bus_key_sequencer.sv
// Bus-snooping key sequencer: matches a programmable sequence of address-nibble
// key steps on window reads, then answers window reads with an LFSR bit stream.
module bus_key_sequencer #(
  parameter int unsigned                ADDR_W     = 14,
  parameter logic [ADDR_W-1:0]          WIN_MASK   = 14'h3000,
  parameter logic [ADDR_W-1:0]          WIN_MATCH  = 14'h1000,
  parameter int unsigned                NIB_LSB    = 4,
  parameter int unsigned                NIB_W      = 4,
  parameter int unsigned                SEQ_LEN    = 4,
  parameter logic [SEQ_LEN*NIB_W-1:0]   KEY        = {4'h9, 4'hB, 4'hA, 4'h2},
  parameter logic [NIB_W-1:0]           RELOCK_NIB = 4'hF,
  parameter int unsigned                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]          LFSR_TAPS  = 8'hB8,
  parameter logic [LFSR_W-1:0]          LFSR_SEED  = 8'h01,
  parameter int unsigned                TMO_W      = 8,
  localparam int unsigned               IDX_W      = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_stb,
  input  logic              bus_rw,
  input  logic              bus_sel_n,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              rd_data,
  output logic              rd_oe,
  output logic              unlocked,
  output logic [IDX_W-1:0]  seq_idx
);

  typedef enum logic {LOCKED, UNLOCKED} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx_d;
  logic [LFSR_W-1:0]  lfsr, lfsr_d, lfsr_adv;
  logic [TMO_W-1:0]   tmo, tmo_d;
  logic               win, hit, fb;
  logic [NIB_W-1:0]   nib, step_k, step_0;

  assign win      = (bus_addr & WIN_MASK) == WIN_MATCH;
  assign hit      = bus_stb & ~bus_sel_n & bus_rw & win;
  assign nib      = bus_addr[NIB_LSB +: NIB_W];
  assign step_0   = KEY[NIB_W-1:0];
  assign unlocked = (state == UNLOCKED);
  assign rd_oe    = ~bus_sel_n & bus_rw & win & unlocked;

  assign fb       = ^(lfsr & LFSR_TAPS);
  assign lfsr_adv = {lfsr[LFSR_W-2:0], fb};

  always_comb begin
    step_k = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (seq_idx == IDX_W'(i)) step_k = KEY[i*NIB_W +: NIB_W];
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = seq_idx;
    lfsr_d  = lfsr;
    tmo_d   = tmo;

    if (hit)
      tmo_d = '0;
    else if (bus_stb && (tmo != '1))
      tmo_d = tmo + TMO_W'(1);

    if (hit) begin
      case (state)
        LOCKED: begin
          lfsr_d = LFSR_SEED;
          if (nib == step_k) begin
            idx_d = seq_idx + IDX_W'(1);
            if (seq_idx == IDX_W'(SEQ_LEN - 1)) state_d = UNLOCKED;
          end else if (nib == step_0) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end
        UNLOCKED: begin
          if (nib == RELOCK_NIB) begin
            state_d = LOCKED;
            idx_d   = '0;
            lfsr_d  = LFSR_SEED;
          end else begin
            lfsr_d  = lfsr_adv;
          end
        end
        default: begin
          state_d = LOCKED;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
        end
      endcase
    end else if (bus_stb && (tmo_d == '1)) begin
      // Idle timeout; a coinciding hit takes the branch above and clears instead
      state_d = LOCKED;
      idx_d   = '0;
      lfsr_d  = LFSR_SEED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOCKED;
      seq_idx <= '0;
      lfsr    <= LFSR_SEED;
      tmo     <= '0;
      rd_data <= 1'b0;
    end else begin
      state   <= state_d;
      seq_idx <= idx_d;
      lfsr    <= lfsr_d;
      tmo     <= tmo_d;
      // Registered copy of the MSB the LFSR will hold after this edge
      rd_data <= lfsr_d[LFSR_W-1];
    end
  end

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Directed bench for bus_key_sequencer; expected values are queued on drive
// and popped when the DUT outputs are sampled.
module tb_bus_key_sequencer;

  localparam logic [7:0] SEED = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_stb = 1'b0;
  logic        bus_rw = 1'b0;
  logic        bus_sel_n = 1'b1;
  logic [13:0] bus_addr = '0;

  logic        rd_data, rd_oe, unlocked;
  logic [2:0]  seq_idx;
  logic        rd_data2, rd_oe2, unlocked2;
  logic [1:0]  seq_idx2;

  always #5 clk = ~clk;

  bus_key_sequencer #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .bus_rw(bus_rw),
    .bus_sel_n(bus_sel_n), .bus_addr(bus_addr), .rd_data(rd_data),
    .rd_oe(rd_oe), .unlocked(unlocked), .seq_idx(seq_idx)
  );

  bus_key_sequencer #(.SEQ_LEN(2), .KEY(8'h3C)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .bus_rw(bus_rw),
    .bus_sel_n(bus_sel_n), .bus_addr(bus_addr), .rd_data(rd_data2),
    .rd_oe(rd_oe2), .unlocked(unlocked2), .seq_idx(seq_idx2)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = 32'(val);
    sbq.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    e = sbq.pop_front();
    tests++;
    assert (obs === e.val) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    sb_push(tag, expv);
    sb_check(obs);
  endtask

  // One bus cycle starting just after a rising edge: rd_oe/rd_data are checked
  // before the edge, seq_idx/unlocked just after it.
  task automatic cyc(input string tag, input int stb, input int rw, input int sel_n,
                     input logic [13:0] addr, input int e_oe, input int e_rd,
                     input int e_idx, input int e_unl);
    sb_push({tag, ".oe"},  e_oe);
    sb_push({tag, ".rd"},  e_rd);
    sb_push({tag, ".idx"}, e_idx);
    sb_push({tag, ".unl"}, e_unl);
    bus_stb   = 1'(stb);
    bus_rw    = 1'(rw);
    bus_sel_n = 1'(sel_n);
    bus_addr  = addr;
    #1;
    sb_check(32'(rd_oe));
    sb_check(32'(rd_data));
    @(posedge clk);
    #1;
    sb_check(32'(seq_idx));
    sb_check(32'(unlocked));
  endtask

  task automatic unlock_main(input string tag);
    cyc({tag, "_k0"}, 1, 1, 0, 14'h1020, 0, 0, 1, 0);
    cyc({tag, "_k1"}, 1, 1, 0, 14'h10A0, 0, 0, 2, 0);
    cyc({tag, "_k2"}, 1, 1, 0, 14'h10B0, 0, 0, 3, 0);
    cyc({tag, "_k3"}, 1, 1, 0, 14'h1090, 0, 0, 4, 1);
  endtask

  // Timeout filler: 254 non-hit strobes with a few idle (no-strobe) cycles mixed in
  task automatic non_hits_254(input string tag);
    for (int i = 1; i <= 254; i++) begin
      if (i % 64 == 0) cyc({tag, "_idle"}, 0, 1, 0, 14'h2000, 0, 0, 4, 1);
      if (i % 2 == 1) cyc({tag, "_wr"},  1, 0, 0, 14'h1000, 0, 0, 4, 1);
      else            cyc({tag, "_oow"}, 1, 1, 0, 14'h2000, 0, 0, 4, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0] rsp;
    rsp = 8'b1000_0000;  // rd_data seen on reads 0..7 after unlock

    assert (SEED != 8'h00) else $fatal(1, "FAIL seed: zero LFSR seed is illegal");

    bus_rw = 1'b1; bus_sel_n = 1'b0; bus_addr = 14'h1000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idx",  32'(seq_idx),   0);
    chk("rst_unl",  32'(unlocked),  0);
    chk("rst_rd",   32'(rd_data),   0);
    chk("rst_oe",   32'(rd_oe),     0);
    chk("rst_idx2", 32'(seq_idx2),  0);
    rst_n = 1'b1;

    // Two-step key on the SEQ_LEN=2 instance (C then 3); neither is a main-key match
    cyc("k2_s0", 1, 1, 0, 14'h10C0, 0, 0, 0, 0);
    chk("k2_s0_idx2", 32'(seq_idx2), 1);
    chk("k2_s0_unl2", 32'(unlocked2), 0);
    cyc("k2_s1", 1, 1, 0, 14'h1030, 0, 0, 0, 0);
    chk("k2_s1_idx2", 32'(seq_idx2), 2);
    chk("k2_s1_unl2", 32'(unlocked2), 1);

    unlock_main("unl1");
    for (int i = 0; i < 7; i++)
      cyc($sformatf("rsp%0d", i), 1, 1, 0, 14'h1000, 1, int'(rsp[i]), 4, 1);

    // Non-hit cycles while unlocked: rd_oe decode without strobe, no state change
    cyc("nostb", 0, 1, 0, 14'h1000, 1, 1, 4, 1);
    cyc("seln",  1, 1, 1, 14'h1000, 0, 1, 4, 1);
    cyc("wr",    1, 0, 0, 14'h1000, 0, 1, 4, 1);
    cyc("oow",   1, 1, 0, 14'h3000, 0, 1, 4, 1);

    cyc("relock",  1, 1, 0, 14'h10F0, 1, int'(rsp[7]), 0, 0);
    cyc("lock_rd", 1, 1, 0, 14'h1000, 0, 0, 0, 0);

    cyc("rs0", 1, 1, 0, 14'h1020, 0, 0, 1, 0);
    cyc("rs1", 1, 1, 0, 14'h10A0, 0, 0, 2, 0);
    cyc("rs2", 1, 1, 0, 14'h1020, 0, 0, 1, 0);
    cyc("rs3", 1, 1, 0, 14'h10A0, 0, 0, 2, 0);
    cyc("rs4", 1, 1, 0, 14'h10B0, 0, 0, 3, 0);
    cyc("rs5", 1, 1, 0, 14'h1090, 0, 0, 4, 1);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("rs_rsp%0d", i), 1, 1, 0, 14'h1000, 1, 0, 4, 1);

    cyc("relock2", 1, 1, 0, 14'h10F0, 1, 0, 0, 0);
    cyc("bad0", 1, 1, 0, 14'h1020, 0, 0, 1, 0);
    cyc("bad1", 1, 1, 0, 14'h10A0, 0, 0, 2, 0);
    cyc("bad2", 1, 1, 0, 14'h1050, 0, 0, 0, 0);

    cyc("lk0",    1, 1, 0, 14'h1020, 0, 0, 1, 0);
    cyc("lk_wr",  1, 0, 0, 14'h10A0, 0, 0, 1, 0);
    cyc("lk_oow", 1, 1, 0, 14'h30A0, 0, 0, 1, 0);
    cyc("lk_sel", 1, 1, 1, 14'h10A0, 0, 0, 1, 0);
    cyc("lk1",    1, 1, 0, 14'h10A0, 0, 0, 2, 0);
    cyc("lk2",    1, 1, 0, 14'h10B0, 0, 0, 3, 0);
    cyc("lk3",    1, 1, 0, 14'h1090, 0, 0, 4, 1);

    non_hits_254("tmoA");
    cyc("tmoA_255", 1, 0, 0, 14'h1000, 0, 0, 0, 0);
    cyc("tmoA_sat", 1, 0, 0, 14'h1000, 0, 0, 0, 0);

    unlock_main("unl2");
    non_hits_254("tmoB");
    cyc("tmoB_hit",   1, 1, 0, 14'h1000, 1, 0, 4, 1);
    cyc("tmoB_after", 1, 0, 0, 14'h1000, 0, 0, 4, 1);

    // LFSR at 02 now; six reads walk it to 8E so rd_data is 1 before reset
    for (int i = 0; i < 6; i++)
      cyc($sformatf("pre_rsp%0d", i), 1, 1, 0, 14'h1000, 1, 0, 4, 1);
    bus_stb = 1'b0; bus_rw = 1'b1; bus_sel_n = 1'b0; bus_addr = 14'h1000;
    #1;
    chk("pre_rst_rd", 32'(rd_data), 1);
    chk("pre_rst_oe", 32'(rd_oe),   1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_unl", 32'(unlocked), 0);
    chk("mid_rst_rd",  32'(rd_data),  0);
    chk("mid_rst_idx", 32'(seq_idx),  0);
    chk("mid_rst_oe",  32'(rd_oe),    0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    unlock_main("unl3");
    for (int i = 0; i < 4; i++)
      cyc($sformatf("post_rsp%0d", i), 1, 1, 0, 14'h1000, 1, 0, 4, 1);

    bus_stb = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bus_key_sequencer.md
Name: bus_key_sequencer

Overview:
- Parametrised bus-snooping key sequencer.
- Watches read cycles that fall in a decoded address window and matches a programmable sequence of address-nibble key steps against them.
- Once the full sequence has matched, returns a pseudo-random response stream from an LFSR on subsequent window reads.
- Sits beside the cartridge/board bus decode. It is the generalised successor of the fixed 6-bit unlock state machine, adding configurable key length, window, nibble field, response width, relock and timeout.

Parameters:
- ADDR_W, 14, bus address width.
- WIN_MASK, 14'h3000, address bits compared for the window.
- WIN_MATCH, 14'h1000, required value of masked bits (A13=0, A12=1).
- NIB_LSB, 4, LSB of the key nibble field in bus_addr.
- NIB_W, 4, key nibble width.
- SEQ_LEN, 4, number of key steps (2..16).
- KEY, {4'h9,4'hB,4'hA,4'h2}, packed key; step i = KEY[i*NIB_W +: NIB_W], step 0 first.
- RELOCK_NIB, 4'hF, nibble that relocks when read while unlocked.
- LFSR_W, 8, response LFSR width.
- LFSR_TAPS, 8'hB8, feedback tap mask.
- LFSR_SEED, 8'h01, non-zero seed.
- TMO_W, 8, width of the idle-timeout counter; timeout fires at all-ones.

Ports:
- clk  in  1  bus-synchronous clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bus_stb  in  1  one-cycle strobe per bus cycle.
- bus_rw  in  1  1 = read, 0 = write.
- bus_sel_n  in  1  chip select, active-low.
- bus_addr  in  ADDR_W  bus address.
- rd_data  out  1  response bit; valid while rd_oe is high.
- rd_oe  out  1  drive enable for rd_data.
- unlocked  out  1  high in the UNLOCKED state.
- seq_idx  out  clog2(SEQ_LEN+1)  current key step.

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-low, on clk.
- Reset values: state LOCKED, seq_idx=0, unlocked=0, rd_data=0, LFSR=LFSR_SEED, timeout counter=0.
- rd_oe is combinational, so it is 0 whenever its decode is false.
- Reset mid-sequence or mid-stream returns everything to these values immediately.

Hits and drive:
- A hit is a cycle with bus_stb=1, bus_sel_n=0, bus_rw=1 and (bus_addr & WIN_MASK)==WIN_MATCH.
- nib = bus_addr[NIB_LSB +: NIB_W].
- Writes and out-of-window cycles never change state; they only feed the timeout.
- rd_oe = bus_sel_n==0 & bus_rw & window match & unlocked. It does not require bus_stb.
- rd_data holds the LFSR MSB captured at the previous edge. It is a registered, zero-wait-state output.

LOCKED (seq_idx = k < SEQ_LEN), on a hit:
- If nib==KEY step k: seq_idx<=k+1. If k+1==SEQ_LEN, go to UNLOCKED in the same edge.
- If nib!=step k but nib==step 0: seq_idx<=1 (restart).
- Otherwise: seq_idx<=0.
- In LOCKED the LFSR holds at LFSR_SEED.

UNLOCKED (seq_idx = SEQ_LEN), on a hit:
- If nib==RELOCK_NIB: go to LOCKED, seq_idx<=0, LFSR<=LFSR_SEED. That read's rd_data is still driven with the current value.
- Otherwise: advance the LFSR one step.
  - fb = ^(lfsr & LFSR_TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - rd_data <= new lfsr[LFSR_W-1] at the next edge, so the read after the advance sees the next bit.
- First read after unlock sees the MSB of LFSR_SEED.

Timeout:
- The counter clears on every hit and increments on every other bus_stb cycle.
- It saturates at all-ones. On reaching all-ones in any non-reset state, force LOCKED, seq_idx=0, LFSR=seed.
- A hit coinciding with the all-ones edge wins: the counter clears and no relock occurs.

Boundary conditions:
- With SEQ_LEN=2, the two-step unlock must work.
- A key whose step 0 repeats inside the key uses only the single-step restart above. No KMP backtracking.
- LFSR never reaches zero given a non-zero seed. A seed of 0 is illegal; the bench asserts seed≠0.

Test Plan:
- Reset then four hits with nib 2,A,B,9 (addr 14'h1020,14'h10A0,14'h10B0,14'h1090) → seq_idx 1,2,3,4; unlocked=1 after 4th edge; rd_oe=0 during all four.
- After unlock, 8 hits with nib 0 → rd_oe=1 each; rd_data sequence 0,0,0,0,0,0,0,1 (LFSR 01,02,04,08,11,23,47,8E).
- Sequence 2,A,2,A,B,9 → seq_idx 1,2,1,2,3,4 → unlocked; sequence 2,A,5 → seq_idx 0.
- Unlocked, hit with nib F → unlocked=0 at next edge, seq_idx=0; next window read rd_oe=0; re-unlock restarts response at 0,0,…
- Unlocked, 255 non-hit strobes (writes or addr 14'h2000) → locked at 255th; a variant with a hit on the 255th strobe stays unlocked.
- Assert rst_n low mid-stream after 3 responses, between clock edges → unlocked, rd_data, seq_idx go to 0 immediately; post-reset unlock replays from seed.
